// File: rtl/obsidian_pkg.sv
// Shared LEGv8 decode constants: opcodes, control-bit positions and control encodings.
package obsidian_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPC_W      = 11;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CTRL_W     = 8;
    localparam int unsigned SHAMT_W    = 6;

    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

    localparam logic [OPC_W-1:0] OPC_ADD  = 11'h458;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'h658;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'h450;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'h550;
    localparam logic [OPC_W-1:0] OPC_EOR  = 11'h650;
    localparam logic [OPC_W-1:0] OPC_ADDS = 11'h558;
    localparam logic [OPC_W-1:0] OPC_SUBS = 11'h758;
    localparam logic [OPC_W-1:0] OPC_ANDS = 11'h750;
    localparam logic [OPC_W-1:0] OPC_LSL  = 11'h69B;
    localparam logic [OPC_W-1:0] OPC_LSR  = 11'h69A;
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'h7C2;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'h7C0;
    localparam logic [9:0]       OPC_ADDI = 10'h244;
    localparam logic [9:0]       OPC_SUBI = 10'h344;
    localparam logic [7:0]       OPC_CBZ  = 8'hB4;
    localparam logic [5:0]       OPC_B    = 6'h05;

    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_BRANCH   = 5;
    localparam int unsigned CTRL_MEMREAD  = 4;
    localparam int unsigned CTRL_MEMWRITE = 3;
    localparam int unsigned CTRL_ALUOP1   = 2;
    localparam int unsigned CTRL_ALUOP0   = 1;
    localparam int unsigned CTRL_ALUSRC   = 0;

    localparam logic [CTRL_W-1:0] CTRL_NONE = 8'h00;
    localparam logic [CTRL_W-1:0] CTRL_R    = CTRL_W'((1 << CTRL_REGWRITE) | (1 << CTRL_ALUOP1));
    localparam logic [CTRL_W-1:0] CTRL_I    = CTRL_W'((1 << CTRL_REGWRITE) | (1 << CTRL_ALUOP1)
                                                    | (1 << CTRL_ALUSRC));
    localparam logic [CTRL_W-1:0] CTRL_LDUR = CTRL_W'((1 << CTRL_REGWRITE) | (1 << CTRL_MEMTOREG)
                                                    | (1 << CTRL_MEMREAD) | (1 << CTRL_ALUSRC));
    localparam logic [CTRL_W-1:0] CTRL_STUR = CTRL_W'((1 << CTRL_MEMWRITE) | (1 << CTRL_ALUSRC));
    localparam logic [CTRL_W-1:0] CTRL_CBZ  = CTRL_W'((1 << CTRL_BRANCH) | (1 << CTRL_ALUOP0));
    localparam logic [CTRL_W-1:0] CTRL_B    = CTRL_W'(1 << CTRL_BRANCH);

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_LOAD,
        FMT_STORE,
        FMT_CB,
        FMT_B
    } fmt_e;

    function automatic fmt_e classify(input logic [INSTR_W-1:0] instr);
        logic [OPC_W-1:0] op;
        op = instr[31:21];
        if (op inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_EOR,
                       OPC_ADDS, OPC_SUBS, OPC_ANDS, OPC_LSL, OPC_LSR})
            return FMT_R;
        if (instr[31:22] == OPC_ADDI || instr[31:22] == OPC_SUBI) return FMT_I;
        if (op == OPC_LDUR)           return FMT_LOAD;
        if (op == OPC_STUR)           return FMT_STORE;
        if (instr[31:24] == OPC_CBZ)  return FMT_CB;
        if (instr[31:26] == OPC_B)    return FMT_B;
        return FMT_NONE;
    endfunction

    function automatic logic [CTRL_W-1:0] ctrl_of(input fmt_e fmt);
        case (fmt)
            FMT_R:     return CTRL_R;
            FMT_I:     return CTRL_I;
            FMT_LOAD:  return CTRL_LDUR;
            FMT_STORE: return CTRL_STUR;
            FMT_CB:    return CTRL_CBZ;
            FMT_B:     return CTRL_B;
            default:   return CTRL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/obsidian_regfile.sv
// Two-read, one-write register file; X31 reads as zero and writes to it are dropped.
module obsidian_regfile
    import obsidian_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a_c,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b_c
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != XZR) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write is visible to the reader so decode never sees stale data.
    function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
        if (addr == XZR)                  return '0;
        if (wr_en && addr == wr_addr)     return wr_data;
        return regs[addr];
    endfunction

    always_comb begin
        rd_data_a_c = read_port(rd_addr_a);
        rd_data_b_c = read_port(rd_addr_b);
    end

endmodule

// File: rtl/obsidian_decode_hazard_stage.sv
// LEGv8 decode stage: control decode, operand read, immediate generation and
// load-use hazard detection feeding a registered ID/EX slot.
module obsidian_decode_hazard_stage
    import obsidian_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [PC_W-1:0]       if_pc,
    input  logic [INSTR_W-1:0]    if_instr,
    output logic                  if_stall,
    input  logic                  ex_flush,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  id_valid,
    output logic [CTRL_W-1:0]     id_ctrl,
    output logic [PC_W-1:0]       id_pc,
    output logic [DATA_W-1:0]     id_rn_data,
    output logic [DATA_W-1:0]     id_rm_data,
    output logic [DATA_W-1:0]     id_imm,
    output logic [OPC_W-1:0]      id_opcode,
    output logic [SHAMT_W-1:0]    id_shamt,
    output logic [REG_ADDR_W-1:0] id_rd,
    output logic [REG_ADDR_W-1:0] id_rn,
    output logic [REG_ADDR_W-1:0] id_rm
);

    fmt_e                  fmt;
    logic [CTRL_W-1:0]     ctrl_dec;
    logic [REG_ADDR_W-1:0] rn_addr;
    logic [REG_ADDR_W-1:0] rm_addr;
    logic [DATA_W-1:0]     imm_dec;
    logic [DATA_W-1:0]     rn_data;
    logic [DATA_W-1:0]     rm_data;

    always_comb begin
        fmt      = classify(if_instr);
        ctrl_dec = ctrl_of(fmt);
        rn_addr  = if_instr[9:5];
        // Stores and CBZ read their data/test register through port 2.
        rm_addr  = (fmt == FMT_STORE || fmt == FMT_CB) ? if_instr[4:0] : if_instr[20:16];
        imm_dec  = '0;
        case (fmt)
            FMT_LOAD, FMT_STORE: imm_dec = DATA_W'($signed(if_instr[20:12]));
            FMT_CB:              imm_dec = DATA_W'($signed(if_instr[23:5]));
            FMT_B:               imm_dec = DATA_W'($signed(if_instr[25:0]));
            FMT_I:               imm_dec = DATA_W'(if_instr[21:10]);
            default:             imm_dec = '0;
        endcase
    end

    obsidian_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wb_regwrite),
        .wr_addr     (wb_addr),
        .wr_data     (wb_data),
        .rd_addr_a   (rn_addr),
        .rd_data_a_c (rn_data),
        .rd_addr_b   (rm_addr),
        .rd_data_b_c (rm_data)
    );

    // Load in ID/EX whose destination feeds the instruction now in decode.
    always_comb begin
        if_stall = 1'b0;
        if (!reset && !ex_flush && if_valid && id_valid && id_ctrl[CTRL_MEMREAD]
            && id_rd != XZR && (id_rd == rn_addr || id_rd == rm_addr))
            if_stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid   <= 1'b0;
            id_ctrl    <= CTRL_NONE;
            id_pc      <= '0;
            id_rn_data <= '0;
            id_rm_data <= '0;
            id_imm     <= '0;
            id_opcode  <= '0;
            id_shamt   <= '0;
            id_rd      <= '0;
            id_rn      <= '0;
            id_rm      <= '0;
        end else if (ex_flush || if_stall || !if_valid) begin
            id_valid <= 1'b0;
            id_ctrl  <= CTRL_NONE;
        end else begin
            id_valid   <= (ctrl_dec != CTRL_NONE);
            id_ctrl    <= ctrl_dec;
            id_pc      <= if_pc;
            id_rn_data <= rn_data;
            id_rm_data <= rm_data;
            id_imm     <= imm_dec;
            id_opcode  <= if_instr[31:21];
            id_shamt   <= if_instr[15:10];
            id_rd      <= if_instr[4:0];
            id_rn      <= rn_addr;
            id_rm      <= rm_addr;
        end
    end

endmodule

// File: tb/tb_obsidian_decode_hazard_stage.sv
// Bench for obsidian_decode_hazard_stage: 32- and 64-bit instances against one spec-level model.
module tb_obsidian_decode_hazard_stage;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        ex_flush;
    logic        wb_regwrite;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data64;

    logic        s_stall, s_valid;
    logic [7:0]  s_ctrl;
    logic [31:0] s_pc, s_rn_data, s_rm_data, s_imm;
    logic [10:0] s_opcode;
    logic [5:0]  s_shamt;
    logic [4:0]  s_rd, s_rn, s_rm;

    logic        w_stall, w_valid;
    logic [7:0]  w_ctrl;
    logic [31:0] w_pc;
    logic [63:0] w_rn_data, w_rm_data, w_imm;
    logic [10:0] w_opcode;
    logic [5:0]  w_shamt;
    logic [4:0]  w_rd, w_rn, w_rm;

    obsidian_decode_hazard_stage #(.DATA_W(32), .PC_W(32), .NUM_REGS(32)) dut32 (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_stall(s_stall), .ex_flush(ex_flush), .wb_regwrite(wb_regwrite), .wb_addr(wb_addr),
        .wb_data(wb_data64[31:0]), .id_valid(s_valid), .id_ctrl(s_ctrl), .id_pc(s_pc),
        .id_rn_data(s_rn_data), .id_rm_data(s_rm_data), .id_imm(s_imm), .id_opcode(s_opcode),
        .id_shamt(s_shamt), .id_rd(s_rd), .id_rn(s_rn), .id_rm(s_rm)
    );

    obsidian_decode_hazard_stage #(.DATA_W(64), .PC_W(32), .NUM_REGS(32)) dut64 (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_stall(w_stall), .ex_flush(ex_flush), .wb_regwrite(wb_regwrite), .wb_addr(wb_addr),
        .wb_data(wb_data64), .id_valid(w_valid), .id_ctrl(w_ctrl), .id_pc(w_pc),
        .id_rn_data(w_rn_data), .id_rm_data(w_rm_data), .id_imm(w_imm), .id_opcode(w_opcode),
        .id_shamt(w_shamt), .id_rd(w_rd), .id_rn(w_rn), .id_rm(w_rm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Spec-level model state: architectural registers and the expected ID/EX slot.
    logic [63:0] mregs [32];
    logic        e_valid;
    logic [7:0]  e_ctrl;
    logic [31:0] e_pc;
    logic [63:0] e_rn_data, e_rm_data, e_imm;
    logic [10:0] e_opcode;
    logic [5:0]  e_shamt;
    logic [4:0]  e_rd, e_rn, e_rm;
    logic        m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_ctrl(input logic [31:0] ins);
        case (ins[31:21])
            11'h458, 11'h658, 11'h450, 11'h550, 11'h650,
            11'h558, 11'h758, 11'h750, 11'h69B, 11'h69A: return 8'h84;
            11'h7C2: return 8'hD1;
            11'h7C0: return 8'h09;
            default: ;
        endcase
        if (ins[31:22] == 10'h244 || ins[31:22] == 10'h344) return 8'h85;
        if (ins[31:24] == 8'hB4) return 8'h22;
        if (ins[31:26] == 6'h05) return 8'h20;
        return 8'h00;
    endfunction

    function automatic logic [4:0] m_port2(input logic [31:0] ins);
        if (ins[31:21] == 11'h7C0 || ins[31:24] == 8'hB4) return ins[4:0];
        return ins[20:16];
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] ins);
        if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) return 64'($signed(ins[20:12]));
        if (ins[31:24] == 8'hB4) return 64'($signed(ins[23:5]));
        if (ins[31:26] == 6'h05) return 64'($signed(ins[25:0]));
        if (ins[31:22] == 10'h244 || ins[31:22] == 10'h344) return 64'(ins[21:10]);
        return 64'd0;
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (wb_regwrite && wb_addr == a) return wb_data64;
        return mregs[a];
    endfunction

    function automatic logic m_hazard();
        logic [4:0] p2;
        p2 = m_port2(if_instr);
        return !reset && !ex_flush && if_valid && e_valid && e_ctrl[4] && e_rd != 5'd31
               && (e_rd == if_instr[9:5] || e_rd == p2);
    endfunction

    task automatic m_step(input logic st);
        logic [63:0] rn_v, rm_v;
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
            e_valid = 0; e_ctrl = 0; e_pc = 0; e_rn_data = 0; e_rm_data = 0; e_imm = 0;
            e_opcode = 0; e_shamt = 0; e_rd = 0; e_rn = 0; e_rm = 0;
        end else begin
            rn_v = m_read(if_instr[9:5]);
            rm_v = m_read(m_port2(if_instr));
            if (wb_regwrite && wb_addr != 5'd31) mregs[wb_addr] = wb_data64;
            if (ex_flush || st || !if_valid) begin
                e_valid = 0;
                e_ctrl  = 0;
            end else begin
                e_ctrl    = m_ctrl(if_instr);
                e_valid   = (e_ctrl != 8'h00);
                e_pc      = if_pc;
                e_rn_data = rn_v;
                e_rm_data = rm_v;
                e_imm     = m_imm(if_instr);
                e_opcode  = if_instr[31:21];
                e_shamt   = if_instr[15:10];
                e_rd      = if_instr[4:0];
                e_rn      = if_instr[9:5];
                e_rm      = m_port2(if_instr);
            end
        end
    endtask

    task automatic cmp_all();
        chk("valid32", 64'(s_valid), 64'(e_valid));     chk("valid64", 64'(w_valid), 64'(e_valid));
        chk("ctrl32", 64'(s_ctrl), 64'(e_ctrl));        chk("ctrl64", 64'(w_ctrl), 64'(e_ctrl));
        chk("pc32", 64'(s_pc), 64'(e_pc));              chk("pc64", 64'(w_pc), 64'(e_pc));
        chk("rn_data32", 64'(s_rn_data), 64'(e_rn_data[31:0]));
        chk("rn_data64", w_rn_data, e_rn_data);
        chk("rm_data32", 64'(s_rm_data), 64'(e_rm_data[31:0]));
        chk("rm_data64", w_rm_data, e_rm_data);
        chk("imm32", 64'(s_imm), 64'(e_imm[31:0]));     chk("imm64", w_imm, e_imm);
        chk("opcode32", 64'(s_opcode), 64'(e_opcode));  chk("opcode64", 64'(w_opcode), 64'(e_opcode));
        chk("shamt32", 64'(s_shamt), 64'(e_shamt));     chk("shamt64", 64'(w_shamt), 64'(e_shamt));
        chk("rd32", 64'(s_rd), 64'(e_rd));              chk("rd64", 64'(w_rd), 64'(e_rd));
        chk("rn32", 64'(s_rn), 64'(e_rn));              chk("rn64", 64'(w_rn), 64'(e_rn));
        chk("rm32", 64'(s_rm), 64'(e_rm));              chk("rm64", 64'(w_rm), 64'(e_rm));
    endtask

    // One clock: stall checked and model advanced mid-cycle, registered outputs checked after the edge.
    task automatic tick();
        logic st;
        @(negedge clk);
        st = m_hazard();
        chk("if_stall32", 64'(s_stall), 64'(st));
        chk("if_stall64", 64'(w_stall), 64'(st));
        m_stall = st;
        m_step(st);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    function automatic logic [31:0] r_type(input logic [10:0] op, input logic [4:0] rd,
                                           input logic [4:0] rn, input logic [4:0] rm,
                                           input logic [5:0] sh);
        return {op, rm, sh, rn, rd};
    endfunction

    function automatic logic [31:0] d_type(input logic [10:0] op, input logic [8:0] imm9,
                                           input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm9, 2'b00, rn, rt};
    endfunction

    function automatic logic [4:0] rand_reg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 8));
        return (r == 5'd8) ? 5'd31 : r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [10:0] rops [10];
        int k;
        rops = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h650,
                 11'h558, 11'h758, 11'h750, 11'h69B, 11'h69A};
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2: return r_type(rops[$urandom_range(0, 9)], rand_reg(), rand_reg(), rand_reg(),
                                   6'($urandom));
            3:       return {($urandom_range(0, 1) != 0) ? 10'h244 : 10'h344, 12'($urandom),
                             rand_reg(), rand_reg()};
            4, 5:    return d_type(11'h7C2, 9'($urandom), rand_reg(), rand_reg());
            6:       return d_type(11'h7C0, 9'($urandom), rand_reg(), rand_reg());
            7:       return {8'hB4, 19'($urandom), rand_reg()};
            8:       return {6'h05, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        e_valid = 0; e_ctrl = 0; e_pc = 0; e_rn_data = 0; e_rm_data = 0; e_imm = 0;
        e_opcode = 0; e_shamt = 0; e_rd = 0; e_rn = 0; e_rm = 0; m_stall = 0;
        reset = 1; if_valid = 0; if_pc = 0; if_instr = 0; ex_flush = 0;
        wb_regwrite = 0; wb_addr = 0; wb_data64 = 0;
        tick(); tick();
        chk("lit_reset_valid", 64'(s_valid), 64'd0);
        chk("lit_reset_pc", 64'(s_pc), 64'd0);
        reset = 0;

        // Reset wipes a previously written X1.
        wb_regwrite = 1; wb_addr = 5'd1; wb_data64 = 64'h55; tick();
        wb_regwrite = 0; reset = 1; tick(); reset = 0;
        if_valid = 1; if_pc = 32'h100; if_instr = r_type(11'h458, 5'd3, 5'd1, 5'd2, 6'd0); tick();
        chk("lit_rst_rn_data", 64'(s_rn_data), 64'd0);
        chk("lit_add_ctrl", 64'(s_ctrl), 64'h84);

        // Write-through bypass and XZR read.
        wb_regwrite = 1; wb_addr = 5'd5; wb_data64 = 64'hDEAD;
        if_pc = 32'h104; if_instr = r_type(11'h458, 5'd6, 5'd5, 5'd31, 6'd0); tick();
        wb_regwrite = 0;
        chk("lit_bypass_rn", 64'(s_rn_data), 64'hDEAD);
        chk("lit_xzr_rm", 64'(s_rm_data), 64'd0);

        // Load-use: one stall cycle, one bubble, then the dependent ADD issues.
        if_pc = 32'h108; if_instr = d_type(11'h7C2, 9'h1FC, 5'd1, 5'd2); tick();
        chk("lit_ldur_imm", 64'(s_imm), 64'hFFFF_FFFC);
        chk("lit_ldur_ctrl", 64'(s_ctrl), 64'hD1);
        if_pc = 32'h10C; if_instr = r_type(11'h458, 5'd4, 5'd2, 5'd3, 6'd0);
        #1 chk("lit_lu_stall", 64'(s_stall), 64'd1);
        tick();
        chk("lit_bubble_valid", 64'(s_valid), 64'd0);
        #1 chk("lit_lu_stall_clear", 64'(s_stall), 64'd0);
        tick();
        chk("lit_add_issue_valid", 64'(s_valid), 64'd1);
        chk("lit_add_issue_rd", 64'(s_rd), 64'd4);

        // STUR uses Rt on port 2; an unrelated load destination does not stall it.
        wb_regwrite = 1; wb_addr = 5'd7; wb_data64 = 64'h77;
        if_pc = 32'h110; if_instr = d_type(11'h7C2, 9'd0, 5'd1, 5'd9); tick();
        wb_regwrite = 0;
        if_pc = 32'h114; if_instr = d_type(11'h7C0, 9'd8, 5'd1, 5'd7);
        #1 chk("lit_stur_nostall", 64'(s_stall), 64'd0);
        tick();
        chk("lit_stur_rm", 64'(s_rm), 64'd7);
        chk("lit_stur_rm_data", 64'(s_rm_data), 64'h77);
        chk("lit_stur_ctrl", 64'(s_ctrl), 64'h09);
        chk("lit_stur_imm", 64'(s_imm), 64'd8);

        // Flush overrides a pending stall.
        if_pc = 32'h118; if_instr = d_type(11'h7C2, 9'd0, 5'd1, 5'd2); tick();
        if_pc = 32'h11C; if_instr = r_type(11'h458, 5'd4, 5'd2, 5'd3, 6'd0); ex_flush = 1;
        #1 chk("lit_flush_nostall", 64'(s_stall), 64'd0);
        tick();
        ex_flush = 0;
        chk("lit_flush_valid", 64'(s_valid), 64'd0);

        // CBZ with imm19 = -1 on the 64-bit instance.
        if_pc = 32'h120; if_instr = {8'hB4, 19'h7FFFF, 5'd3}; tick();
        chk("lit_cbz_imm64", w_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lit_cbz_ctrl64", 64'(w_ctrl), 64'h22);

        // Unknown encoding gives an empty slot.
        if_instr = 32'h0; tick();
        chk("lit_illegal_valid", 64'(s_valid), 64'd0);
        chk("lit_illegal_ctrl", 64'(s_ctrl), 64'd0);

        // Reset during a stall drops the held instruction.
        if_instr = d_type(11'h7C2, 9'd0, 5'd1, 5'd2); tick();
        if_instr = r_type(11'h458, 5'd4, 5'd2, 5'd3, 6'd0); reset = 1; tick();
        chk("lit_rst_stall_valid", 64'(s_valid), 64'd0);
        reset = 0; tick();

        for (int n = 0; n < 3000; n++) begin
            if (!m_stall) begin
                if_valid = ($urandom_range(0, 9) != 0);
                if_instr = rand_instr();
                if_pc    = $urandom;
            end
            ex_flush    = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            wb_regwrite = ($urandom_range(0, 1) != 0);
            wb_addr     = rand_reg();
            wb_data64   = {$urandom, $urandom};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obsidian_decode_hazard_stage.md
OBSIDIAN_DECODE_HAZARD_STAGE -- requirements
Module: obsidian_decode_hazard_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and immediate datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-003 SHALL have parameter NUM_REGS, default 32, meaning register-file depth; index 31 is always XZR.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port if_valid, input, 1 bit: the IF/ID instruction is valid.
REQ-007 SHALL have port if_pc, input, PC_W bits: PC of the IF/ID instruction.
REQ-008 SHALL have port if_instr, input, 32 bits: the LEGv8 instruction word.
REQ-009 SHALL have port if_stall, output, 1 bit: when high, fetch holds IF/ID.
REQ-010 SHALL have port ex_flush, input, 1 bit: taken branch; kill the instruction in decode.
REQ-011 SHALL have ports wb_regwrite (input, 1 bit), wb_addr (input, 5 bits) and wb_data (input, DATA_W bits): the writeback port.
REQ-012 SHALL have port id_valid, output, 1 bit: the ID/EX slot holds a real instruction.
REQ-013 SHALL have port id_ctrl, output, 8 bits: {RegWrite, MemtoReg, Branch, MemRead, MemWrite, ALUOp1, ALUOp0, ALUSrc}.
REQ-014 SHALL have ports id_pc (output, PC_W bits), id_rn_data (output, DATA_W bits), id_rm_data (output, DATA_W bits) and id_imm (output, DATA_W bits).
REQ-015 SHALL have ports id_opcode (output, 11 bits), id_shamt (output, 6 bits), id_rd (output, 5 bits), id_rn (output, 5 bits) and id_rm (output, 5 bits); the last three are register addresses for EX forwarding.

Function
REQ-016 SHALL register all id_* outputs with 1-cycle latency from IF/ID.
REQ-017 SHALL decode id_ctrl as follows, all fields fixed with no X values:
- R-type (ADD 458, SUB 658, AND 450, ORR 550, EOR 650, ADDS 558, SUBS 758, ANDS 750, LSL 69B, LSR 69A) -> 8'h84.
- ADDI/SUBI ([31:22] = 244/344) -> 8'h85.
- LDUR 7C2 -> 8'hD1.
- STUR 7C0 -> 8'h09.
- CBZ ([31:24] = B4) -> 8'h22.
- B ([31:26] = 05) -> 8'h20.
- Any other encoding -> 8'h00, with id_valid=0.
REQ-018 SHALL select read port 2 from instr[4:0] for STUR/CBZ (Reg2Loc) and from instr[20:16] otherwise; id_rm SHALL carry the selected address.
REQ-019 SHALL generate id_imm as follows:
- D-type: sign-extend [20:12].
- CB: sign-extend [23:5].
- B: sign-extend [25:0].
- I-type: zero-extend [21:10].
- All others: 0.
REQ-020 SHALL pass id_shamt=instr[15:10], id_opcode=instr[31:21], id_rd=instr[4:0] and id_pc=if_pc.
REQ-021 SHALL return 0 for any read of register 31 and SHALL ignore writes to register 31.
REQ-022 SHALL write the register file when wb_regwrite=1; a same-cycle read of wb_addr SHALL return wb_data (write-through bypass).
REQ-023 SHALL assert if_stall combinationally on a load-use hazard, defined as all of the following:
- id_valid=1 and id_ctrl MemRead=1;
- id_rd!=31;
- if_valid=1;
- id_rd equals the decoding instruction's Rn or its used port-2 register.
REQ-024 SHALL insert a bubble on the edge where if_stall=1: id_valid=0 and id_ctrl=0, with the other id_* fields holding their values.
REQ-025 SHALL give ex_flush priority over stall and decode: next id_valid=0 and id_ctrl=0, and if_stall=0 while ex_flush=1.
REQ-026 SHALL produce id_valid=0 and id_ctrl=0 when if_valid=0.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, clear all id_* outputs and all register-file entries to 0; if_stall SHALL be 0 during reset.
REQ-028 SHALL give reset priority over ex_flush, writeback and decode; reset mid-stall SHALL discard the held instruction.

Structure
REQ-029 SHALL take the opcode constants, ctrl bit indices and 8-bit ctrl encodings from a shared package, obsidian_pkg.
REQ-030 SHALL instantiate the register file as one sub-module, obsidian_regfile, with two read ports, one write port, write-through bypass and XZR handling.
REQ-031 SHALL keep the hazard logic combinational in the top level, with no additional state.

Verification
REQ-032 Reset with X1 previously written, then ADD X3,X1,X2 -> id_rn_data=0 and id_ctrl=8'h84 one cycle later.
REQ-033 wb_regwrite=1, wb_addr=5, wb_data=0xDEAD in the same cycle as decoding ADD X6,X5,X31 -> id_rn_data=0xDEAD and id_rm_data=0.
REQ-034 LDUR X2,[X1,#-4] then ADD X4,X2,X3 -> id_imm=0xFFFFFFFC; if_stall=1 for exactly 1 cycle; one bubble (id_valid=0); ADD issues next.
REQ-035 STUR X7,[X1,#8] -> port 2 reads X7, id_ctrl=8'h09, id_imm=8; no stall when the preceding LDUR writes X9.
REQ-036 Stall cycle coincident with ex_flush=1 -> if_stall=0 and next id_valid=0.
REQ-037 DATA_W=64, CBZ with imm19=-1 -> id_imm=64'hFFFF_FFFF_FFFF_FFFF and id_ctrl=8'h22.
